// File: rtl/io_pkg.sv
// Shared constants for the input capture block: register map, input widths and button naming.
package io_pkg;

    localparam int SW_W  = 16;
    localparam int BTN_W = 5;
    localparam int IN_W  = SW_W + BTN_W;

    // Byte offsets of the four readable words
    localparam logic [3:0] REG_SW_OFS     = 4'h0;
    localparam logic [3:0] REG_BTN_OFS    = 4'h4;
    localparam logic [3:0] REG_FLAGS_OFS  = 4'h8;
    localparam logic [3:0] REG_STATUS_OFS = 4'hC;

    typedef enum logic [2:0] {
        BTN_C = 3'd0,
        BTN_U = 3'd1,
        BTN_L = 3'd2,
        BTN_R = 3'd3,
        BTN_D = 3'd4
    } btn_idx_e;

    // Byte lanes are ignored; only the word index selects a register
    function automatic logic [1:0] word_sel(input logic [3:0] ofs);
        return ofs[3:2];
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// One-bit synchronizer plus sample-based debouncer; the sample tick is shared from the parent.
module input_debouncer
    import io_pkg::*;
#(
    parameter int STABLE_SAMPLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_tick,
    input  logic raw,
    output logic db
);

    localparam int CW = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES + 1) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(STABLE_SAMPLES - 1);

    logic          meta_reg;
    logic          sync_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          db_reg;
    logic          db_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            cnt_reg  <= '0;
            db_reg   <= 1'b0;
        end else begin
            meta_reg <= raw;
            sync_reg <= meta_reg;
            cnt_reg  <= cnt_next;
            db_reg   <= db_next;
        end
    end

    // The tick that would bring the count to STABLE_SAMPLES accepts the new level instead
    always_comb begin
        cnt_next = cnt_reg;
        db_next  = db_reg;
        if (sample_tick) begin
            if (sync_reg != db_reg) begin
                if (cnt_reg == LAST_CNT) begin
                    db_next  = sync_reg;
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end else begin
                cnt_next = '0;
            end
        end
    end

    assign db = db_reg;

endmodule

// File: rtl/input_capture_subsystem.sv
// Debounced switch/button capture with a registered read port and clear-on-read press flags.
// Define INPUT_IRQ_EN to add the press-pending irq output.
module input_capture_subsystem
    import io_pkg::*;
#(
    parameter int SAMPLE_DIV     = 25000,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SW_W-1:0]   sw,
    input  logic [BTN_W-1:0]  btn,
    input  logic              rd_en,
    input  logic [3:0]        rd_addr,
    output logic [31:0]       rd_data,
    output logic              rd_valid
`ifdef INPUT_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SAMPLE_DIV - 1);

    localparam logic [1:0] SW_WORD     = REG_SW_OFS[3:2];
    localparam logic [1:0] BTN_WORD    = REG_BTN_OFS[3:2];
    localparam logic [1:0] FLAGS_WORD  = REG_FLAGS_OFS[3:2];
    localparam logic [1:0] STATUS_WORD = REG_STATUS_OFS[3:2];

    logic [PW-1:0]    pre_reg;
    logic [PW-1:0]    pre_next;
    logic             sample_tick;

    logic [IN_W-1:0]  raw_vec;
    logic [IN_W-1:0]  db_vec;
    logic [SW_W-1:0]  sw_db;
    logic [BTN_W-1:0] btn_db;

    logic [BTN_W-1:0] btn_db_prev_reg;
    logic [BTN_W-1:0] press_rise;
    logic [BTN_W-1:0] flags_reg;
    logic [BTN_W-1:0] flags_next;
    logic             flags_rd;

    logic [31:0]      rd_data_reg;
    logic [31:0]      rd_data_next;
    logic             rd_valid_reg;

    // Sample prescaler
    always_comb begin
        sample_tick = (pre_reg == PRE_LAST);
        pre_next    = sample_tick ? '0 : pre_reg + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_reg <= '0;
        end else begin
            pre_reg <= pre_next;
        end
    end

    // Switches occupy the low bits, buttons the high bits of the debouncer bank
    assign raw_vec = {btn, sw};

    generate
        for (genvar gi = 0; gi < IN_W; gi++) begin : g_db
            input_debouncer #(
                .STABLE_SAMPLES (STABLE_SAMPLES)
            ) u_db (
                .clk         (clk),
                .reset       (reset),
                .sample_tick (sample_tick),
                .raw         (raw_vec[gi]),
                .db          (db_vec[gi])
            );
        end
    endgenerate

    assign sw_db  = db_vec[SW_W-1:0];
    assign btn_db = db_vec[IN_W-1:SW_W];

    // A press set and a clear-on-read landing together leave the flag set
    always_comb begin
        press_rise = btn_db & ~btn_db_prev_reg;
        flags_rd   = rd_en && (word_sel(rd_addr) == FLAGS_WORD);
        flags_next = (flags_reg & ~{BTN_W{flags_rd}}) | press_rise;
    end

    always_comb begin
        rd_data_next = '0;
        if (rd_en) begin
            unique case (word_sel(rd_addr))
                SW_WORD:     rd_data_next = {{(32 - SW_W){1'b0}}, sw_db};
                BTN_WORD:    rd_data_next = {{(32 - BTN_W){1'b0}}, btn_db};
                FLAGS_WORD:  rd_data_next = {{(32 - BTN_W){1'b0}}, flags_reg};
                STATUS_WORD: rd_data_next = {31'b0, |flags_reg};
                default:     rd_data_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_db_prev_reg <= '0;
            flags_reg       <= '0;
            rd_data_reg     <= '0;
            rd_valid_reg    <= 1'b0;
        end else begin
            btn_db_prev_reg <= btn_db;
            flags_reg       <= flags_next;
            rd_valid_reg    <= rd_en;
            if (rd_en) begin
                rd_data_reg <= rd_data_next;
            end
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;

`ifdef INPUT_IRQ_EN
    logic irq_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= |flags_reg;
        end
    end

    assign irq = irq_reg;
`endif

endmodule

// File: tb/tb_input_capture_subsystem.sv
// Randomized bench for input_capture_subsystem against a level-based reference model.
module tb_input_capture_subsystem;

    localparam int SAMPLE_DIV     = 4;
    localparam int STABLE_SAMPLES = 2;
    localparam int HOLD           = 20;

    logic        clk;
    logic        reset;
    logic [15:0] sw;
    logic [4:0]  btn;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
`ifdef INPUT_IRQ_EN
    logic        irq;
`endif

    input_capture_subsystem #(
        .SAMPLE_DIV     (SAMPLE_DIV),
        .STABLE_SAMPLES (STABLE_SAMPLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .btn      (btn),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
`ifdef INPUT_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: accepted levels and pending presses
    logic [15:0] m_sw;
    logic [4:0]  m_btn;
    logic [4:0]  m_flags;

    int n_vec;
    int n_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_sw    = '0;
        m_btn   = '0;
        m_flags = '0;
    endtask

    task automatic check_irq(input string tag);
`ifdef INPUT_IRQ_EN
        check_eq(tag, 32'(irq), 32'(|m_flags));
`else
        n_vec = n_vec + 0;
`endif
    endtask

    // A level held long enough is accepted; a button going 0->1 between levels is a press
    task automatic apply_level(input logic [15:0] s, input logic [4:0] b);
        m_flags = m_flags | (b & ~m_btn);
        m_sw    = s;
        m_btn   = b;
        sw      = s;
        btn     = b;
        step(HOLD);
        check_irq("irq_level");
    endtask

    // Short excursion away from the accepted level; must not be accepted
    task automatic glitch(input logic [15:0] ms, input logic [4:0] mb, input int len);
        sw  = m_sw ^ ms;
        btn = m_btn ^ mb;
        step(len);
        sw  = m_sw;
        btn = m_btn;
        step(12);
    endtask

    task automatic expected_read(input logic [3:0] a, output logic [31:0] d);
        case (a[3:2])
            2'd0: d = {16'b0, m_sw};
            2'd1: d = {27'b0, m_btn};
            2'd2: begin
                d       = {27'b0, m_flags};
                m_flags = '0;
            end
            default: d = {31'b0, |m_flags};
        endcase
    endtask

    // Back-to-back reads, one per cycle
    task automatic read_seq(input logic [3:0] a[4], input int n);
        logic [31:0] exp_d;
        for (int i = 0; i < n; i++) begin
            rd_en   = 1'b1;
            rd_addr = a[i];
            expected_read(a[i], exp_d);
            @(negedge clk);
            $display("read addr=%h data=%08h valid=%0b exp=%08h", a[i], rd_data, rd_valid, exp_d);
            check_eq("rd_valid", 32'(rd_valid), 32'd1);
            check_eq($sformatf("rd_data@%h", a[i]), rd_data, exp_d);
        end
        rd_en = 1'b0;
        @(negedge clk);
        check_eq("rd_valid_idle", 32'(rd_valid), 32'd0);
        check_irq("irq_after_read");
    endtask

    task automatic read_one(input logic [3:0] a);
        logic [3:0] q[4];
        q = '{a, 4'h0, 4'h0, 4'h0};
        read_seq(q, 1);
    endtask

    initial begin
        logic [3:0]  q[4];
        logic [31:0] d;
        int          hits;
        int          nr;

        n_vec   = 0;
        n_err   = 0;
        reset   = 1'b1;
        sw      = '0;
        btn     = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        model_reset();
        step(3);
        check_eq("reset_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("reset_rd_data", rd_data, 32'd0);
        check_irq("reset_irq");
        reset = 1'b0;
        step(2);

        // Switch level capture
        apply_level(16'hA5A5, 5'h00);
        read_one(4'h0);

        // Short button pulse is rejected
        glitch(16'h0000, 5'h01, 3);
        q = '{4'h4, 4'h8, 4'h0, 4'h0};
        read_seq(q, 2);

        // Held button: flag reads once, then clears
        apply_level(16'hA5A5, 5'h04);
        q = '{4'h8, 4'h8, 4'h0, 4'h0};
        read_seq(q, 2);

        // Byte lanes ignored
        q = '{4'h1, 4'h5, 4'hE, 4'hB};
        read_seq(q, 4);

        // New press debouncing under a continuous stream of flag reads: seen exactly once
        apply_level(16'h1234, 5'h00);
        read_one(4'h8);
        btn     = 5'h02;
        m_btn   = 5'h02;
        hits    = 0;
        for (int i = 0; i < 24; i++) begin
            rd_en   = 1'b1;
            rd_addr = 4'h8;
            @(negedge clk);
            check_eq("stream_valid", 32'(rd_valid), 32'd1);
            check_eq("stream_other_bits", rd_data & ~32'h2, 32'd0);
            if (rd_data[1]) hits++;
        end
        rd_en = 1'b0;
        step(2);
        check_eq("stream_press_hits", 32'(hits), 32'd1);
        read_one(4'h8);

        // Randomized levels, glitches and read bursts
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1)
                glitch(16'($urandom), 5'($urandom_range(0, 31)), $urandom_range(1, SAMPLE_DIV));
            apply_level(16'($urandom), 5'($urandom_range(0, 31)));
            nr = $urandom_range(1, 4);
            for (int k = 0; k < 4; k++) q[k] = 4'($urandom_range(0, 15));
            read_seq(q, nr);
        end

        // Reset while all flags pending and a read is in flight
        apply_level(16'hFFFF, 5'h00);
        read_one(4'h8);
        apply_level(16'hFFFF, 5'h1F);
        rd_en   = 1'b1;
        rd_addr = 4'h8;
        #2 reset = 1'b1;
        sw  = '0;
        btn = '0;
        model_reset();
        @(negedge clk);
        check_eq("reset_mid_read_valid", 32'(rd_valid), 32'd0);
        check_eq("reset_mid_read_data", rd_data, 32'd0);
        rd_en = 1'b0;
        step(2);
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_reset_valid", 32'(rd_valid), 32'd0);
        step(HOLD);
        q = '{4'h0, 4'h4, 4'h8, 4'hC};
        read_seq(q, 4);

        // Button held through reset produces one press after release
        reset = 1'b1;
        btn   = 5'h10;
        step(2);
        model_reset();
        reset = 1'b0;
        apply_level(16'h0000, 5'h10);
        q = '{4'h8, 4'h8, 4'hC, 4'h4};
        read_seq(q, 4);

        expected_read(4'h4, d);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
